// File: rtl/hbm_tile_loader_pkg.sv
// Shared memory-path package: element/beat/tile/bank types, tile geometry
// constants and the fill FSM state encoding used by hbm_tile_loader.
package dal_mem_pkg;

  localparam int WIDTH      = 16;   // element width in bits
  localparam int TILE_SIZE  = 128;  // elements per tile
  localparam int BEAT_ELEMS = 16;   // elements per HBM beat
  localparam int NUM_BANKS  = 8;    // destination banks

  localparam int BEATS      = TILE_SIZE / BEAT_ELEMS;
  localparam int BANK_W     = $clog2(NUM_BANKS);
  localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_W     = BEAT_ELEMS * WIDTH;
  localparam int TILE_W     = TILE_SIZE * WIDTH;

  typedef logic [WIDTH-1:0]      elem_t;
  typedef logic [BEAT_W-1:0]     beat_t;
  typedef logic [TILE_W-1:0]     tile_t;
  typedef logic [BANK_W-1:0]     bank_t;
  typedef logic [BEAT_CNT_W-1:0] beat_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Number of empty entries in a two-entry ping-pong buffer.
  function automatic logic [1:0] count_free(input logic [1:0] full);
    return 2'd2 - {1'b0, full[0]} - {1'b0, full[1]};
  endfunction

endpackage

// File: rtl/hbm_tile_loader_if.sv
// Handshake bundle of hbm_tile_loader: load command, HBM beat stream,
// tile output and busy flag. The loader connects through the slave modport.
interface hbm_tile_loader_if;
  import dal_mem_pkg::*;

  logic  cmd_valid_i;
  logic  cmd_ready_o;
  bank_t cmd_bank_i;
  logic  hbm_valid_i;
  logic  hbm_ready_o;
  beat_t hbm_data_i;
  logic  tile_valid_o;
  logic  tile_ready_i;
  bank_t tile_bank_o;
  tile_t tile_data_o;
  logic  busy_o;

  modport master (
    output cmd_valid_i, cmd_bank_i, hbm_valid_i, hbm_data_i, tile_ready_i,
    input  cmd_ready_o, hbm_ready_o, tile_valid_o, tile_bank_o, tile_data_o, busy_o
  );

  modport slave (
    input  cmd_valid_i, cmd_bank_i, hbm_valid_i, hbm_data_i, tile_ready_i,
    output cmd_ready_o, hbm_ready_o, tile_valid_o, tile_bank_o, tile_data_o, busy_o
  );

endinterface

// File: rtl/hbm_tile_loader_tile_pingpong_buf.sv
// Two-entry tile buffer: beat-indexed write into the wr_ptr entry, whole-tile
// read from the rd_ptr entry, and a free-entry count for command admission.
module tile_pingpong_buf
  import dal_mem_pkg::*;
(
  input  logic      clk,
  input  logic      srst,
  input  logic      tag_we,    // command accepted: latch bank tag of wr entry
  input  bank_t     tag_in,
  input  logic      beat_we,   // beat accepted: store into wr entry
  input  beat_idx_t beat_idx,
  input  beat_t     beat_in,
  input  logic      commit,    // last beat accepted: wr entry becomes full
  input  logic      drain,     // rd entry consumed downstream
  output logic      rd_full,
  output bank_t     rd_tag,
  output tile_t     rd_data,
  output logic [1:0] free_cnt
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] full_reg;
  bank_t      tag_reg  [2];
  beat_t      data_reg [2][BEATS];

  // Pointers advance on completion of a fill and on each drain.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (commit) wr_ptr_reg <= ~wr_ptr_reg;
      if (drain)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Full flags; commit and drain always address different entries, because a
  // fill only starts into an empty entry and a drain only hits a full one.
  always_ff @(posedge clk) begin
    if (srst) begin
      full_reg <= 2'b00;
    end else begin
      if (commit) full_reg[wr_ptr_reg] <= 1'b1;
      if (drain)  full_reg[rd_ptr_reg] <= 1'b0;
    end
  end

  // Payload and tag storage; stale contents are masked by the full flag.
  always_ff @(posedge clk) begin
    if (tag_we)  tag_reg[wr_ptr_reg]            <= tag_in;
    if (beat_we) data_reg[wr_ptr_reg][beat_idx] <= beat_in;
  end

  assign rd_full  = full_reg[rd_ptr_reg];
  assign rd_tag   = rd_full ? tag_reg[rd_ptr_reg] : '0;
  assign free_cnt = count_free(full_reg);

  // Reassemble the read tile beat by beat; zero while nothing is presented.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_rd_beat
    assign rd_data[gi*BEAT_W +: BEAT_W] = rd_full ? data_reg[rd_ptr_reg][gi] : '0;
  end

endmodule

// File: rtl/hbm_tile_loader.sv
// hbm_tile_loader: assembles HBM beats into bank-tagged tiles through a
// ping-pong buffer and presents them on a valid/ready output.
// Optional feature macro: HBM_TILE_LOADER_PERF_EN adds stall_cnt_o, a
// saturating count of fill-starved and output-backpressured cycles.
module hbm_tile_loader
  import dal_mem_pkg::*;
(
  input  logic             CLK_i,
  input  logic             RST_i,
  hbm_tile_loader_if.slave bus
`ifdef HBM_TILE_LOADER_PERF_EN
  ,
  output logic [31:0]      stall_cnt_o
`endif
);

  fill_state_e state_reg, state_next;
  beat_idx_t   beat_cnt_reg, beat_cnt_next;
  logic        hbm_ready_reg;
  logic        cmd_ready;
  logic        cmd_fire;
  logic        beat_fire;
  logic        last_beat;
  logic        drain_fire;
  logic        buf_full;
  logic [1:0]  free_cnt;

  assign cmd_ready  = (state_reg == IDLE) && (free_cnt != 2'd0);
  assign drain_fire = buf_full && bus.tile_ready_i;

  // Fill FSM state, beat counter and registered beat-ready.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_reg     <= IDLE;
      beat_cnt_reg  <= '0;
      hbm_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      hbm_ready_reg <= (state_next == FILL);
    end
  end

  // Next-state: accept a command when idle, then collect BEATS beats.
  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    cmd_fire      = 1'b0;
    beat_fire     = 1'b0;
    last_beat     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid_i && cmd_ready) begin
          cmd_fire      = 1'b1;
          beat_cnt_next = '0;
          state_next    = FILL;
        end
      end
      FILL: begin
        if (bus.hbm_valid_i && hbm_ready_reg) begin
          beat_fire = 1'b1;
          if (beat_cnt_reg == BEAT_CNT_W'(BEATS - 1)) begin
            last_beat     = 1'b1;
            beat_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  tile_pingpong_buf u_buf (
    .clk      (CLK_i),
    .srst     (RST_i),
    .tag_we   (cmd_fire),
    .tag_in   (bus.cmd_bank_i),
    .beat_we  (beat_fire),
    .beat_idx (beat_cnt_reg),
    .beat_in  (bus.hbm_data_i),
    .commit   (last_beat),
    .drain    (drain_fire),
    .rd_full  (buf_full),
    .rd_tag   (bus.tile_bank_o),
    .rd_data  (bus.tile_data_o),
    .free_cnt (free_cnt)
  );

  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.hbm_ready_o  = hbm_ready_reg;
  assign bus.tile_valid_o = buf_full;
  assign bus.busy_o       = (state_reg != IDLE) || (free_cnt != 2'd2);

`ifdef HBM_TILE_LOADER_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [1:0]  stall_inc;
  logic [32:0] stall_sum;

  // Both stall sources may hit in one cycle, so the increment is 0..2.
  always_comb begin
    stall_inc = {1'b0, (state_reg == FILL) && !bus.hbm_valid_i}
              + {1'b0, buf_full && !bus.tile_ready_i};
    stall_sum = {1'b0, stall_cnt_reg} + {31'b0, stall_inc};
  end

  // Saturating stall counter.
  always_ff @(posedge CLK_i) begin
    if (RST_i) stall_cnt_reg <= '0;
    else       stall_cnt_reg <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hbm_tile_loader.sv
// Directed bench for hbm_tile_loader: reset, fill/drain ordering, ping-pong
// boundaries, mid-fill reset and back-to-back throughput.
module tb_hbm_tile_loader;
  import dal_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  hbm_tile_loader_if bus();

`ifdef HBM_TILE_LOADER_PERF_EN
  logic [31:0] stall_cnt;
`endif

  hbm_tile_loader dut (
    .CLK_i (clk),
    .RST_i (rst),
    .bus   (bus)
`ifdef HBM_TILE_LOADER_PERF_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tile_t mk_tile(input int base);
    tile_t t;
    for (int n = 0; n < TILE_SIZE; n++) t[n*WIDTH +: WIDTH] = WIDTH'(base + n);
    return t;
  endfunction

  function automatic beat_t mk_beat(input int base, input int k);
    beat_t b;
    for (int j = 0; j < BEAT_ELEMS; j++) b[j*WIDTH +: WIDTH] = WIDTH'(base + BEAT_ELEMS*k + j);
    return b;
  endfunction

  task automatic chk_tile(input string tag, input int base);
    tile_t exp_t;
    tile_t obs_t;
    int    bad;
    exp_t = mk_tile(base);
    obs_t = bus.tile_data_o;
    bad   = 0;
    for (int n = TILE_SIZE - 1; n >= 0; n--)
      if (obs_t[n*WIDTH +: WIDTH] !== exp_t[n*WIDTH +: WIDTH]) bad = n;
    checks++;
    assert (obs_t === exp_t) else begin
      failures++;
      $error("FAIL %s elem[%0d] observed=%0h expected=%0h", tag, bad,
             obs_t[bad*WIDTH +: WIDTH], exp_t[bad*WIDTH +: WIDTH]);
    end
  endtask

  task automatic send_cmd(input string tag, input int bank);
    int waited;
    waited = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_bank_i  = bank_t'(bank);
    while (bus.cmd_ready_o !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
    tick();
    bus.cmd_valid_i = 1'b0;
    chk({tag, "_hbm_ready"}, 32'(bus.hbm_ready_o), 32'd1);
    $display("cmd  %s bank=%0d accepted", tag, bank);
  endtask

  // Streams BEATS beats; with gap set, one idle cycle precedes beats 1..BEATS-1.
  task automatic send_beats(input string tag, input int base, input bit gap,
                            input bit ready_last, input bit pre_valid);
    for (int k = 0; k < BEATS; k++) begin
      if (gap && k > 0) begin
        bus.hbm_valid_i = 1'b0;
        bus.hbm_data_i  = {BEAT_ELEMS{16'hDEAD}};
        tick();
      end
      bus.hbm_valid_i = 1'b1;
      bus.hbm_data_i  = mk_beat(base, k);
      if (k == BEATS - 1) begin
        chk({tag, "_pre_last_valid"}, 32'(bus.tile_valid_o), 32'(pre_valid));
        if (ready_last) bus.tile_ready_i = 1'b1;
      end
      tick();
    end
    bus.hbm_valid_i = 1'b0;
    $display("fill %s base=%0d done", tag, base);
  endtask

  task automatic drain_one(input string tag);
    bus.tile_ready_i = 1'b1;
    tick();
    bus.tile_ready_i = 1'b0;
    chk({tag, "_drained_valid"}, 32'(bus.tile_valid_o), 32'd0);
    $display("tile %s drained", tag);
  endtask

  initial begin
    int issued;
    int filled;
    int beat_k;
    int drained;
    int last_cyc;
    int cyc;
    bit cmd_hs;
    bit beat_hs;

    rst              = 1'b1;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_bank_i   = '0;
    bus.hbm_valid_i  = 1'b0;
    bus.hbm_data_i   = '0;
    bus.tile_ready_i = 1'b0;
    tick();
    tick();

    // 1: reset state, then a plain 8-beat load to bank 3
    chk("rst_tile_valid", 32'(bus.tile_valid_o), 32'd0);
    chk("rst_hbm_ready",  32'(bus.hbm_ready_o),  32'd0);
    chk("rst_busy",       32'(bus.busy_o),       32'd0);
    chk("rst_cmd_ready",  32'(bus.cmd_ready_o),  32'd1);
    chk("rst_tile_bank",  32'(bus.tile_bank_o),  32'd0);
    chk("rst_tile_data_nonzero", 32'(|bus.tile_data_o), 32'd0);
`ifdef HBM_TILE_LOADER_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    send_cmd("t1", 3);
    chk("t1_fill_busy",      32'(bus.busy_o),      32'd1);
    chk("t1_fill_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    send_beats("t1", 0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus.tile_valid_o), 32'd1);
    chk("t1_bank",  32'(bus.tile_bank_o),  32'd3);
    chk_tile("t1_data", 0);
    tick(); tick(); tick();
    chk("t1_hold_valid", 32'(bus.tile_valid_o), 32'd1);
    chk("t1_hold_bank",  32'(bus.tile_bank_o),  32'd3);
    chk_tile("t1_hold_data", 0);
    drain_one("t1");
    chk("t1_idle_busy", 32'(bus.busy_o), 32'd0);

    // 2: beats interleaved with idle cycles; fresh reset zeroes the stall count
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_cmd("t2", 3);
    send_beats("t2", 0, 1'b1, 1'b0, 1'b0);
    chk("t2_valid", 32'(bus.tile_valid_o), 32'd1);
    chk("t2_bank",  32'(bus.tile_bank_o),  32'd3);
    chk_tile("t2_data", 0);
`ifdef HBM_TILE_LOADER_PERF_EN
    chk("t2_stall_cnt", stall_cnt, 32'd7);
`endif
    drain_one("t2");

    // 3: output stalled, two tiles fill, third command waits
    send_cmd("t3a", 1);
    send_beats("t3a", 100, 1'b0, 1'b0, 1'b0);
    chk("t3a_valid", 32'(bus.tile_valid_o), 32'd1);
    chk("t3a_bank",  32'(bus.tile_bank_o),  32'd1);
    send_cmd("t3b", 2);
    send_beats("t3b", 200, 1'b0, 1'b0, 1'b1);
    chk("t3_full_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("t3_full_busy",      32'(bus.busy_o),      32'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_bank_i  = bank_t'(5);
    tick();
    tick();
    chk("t3c_blocked_hbm_ready", 32'(bus.hbm_ready_o), 32'd0);
    chk("t3c_blocked_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("t3_first_bank", 32'(bus.tile_bank_o), 32'd1);
    chk_tile("t3a_data", 100);
    bus.tile_ready_i = 1'b1;
    tick();
    chk("t3_second_valid", 32'(bus.tile_valid_o), 32'd1);
    chk("t3_second_bank",  32'(bus.tile_bank_o),  32'd2);
    chk_tile("t3b_data", 200);
    chk("t3_one_free_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    tick();
    bus.tile_ready_i = 1'b0;
    bus.cmd_valid_i  = 1'b0;
    chk("t3c_hbm_ready", 32'(bus.hbm_ready_o),  32'd1);
    chk("t3c_empty_out", 32'(bus.tile_valid_o), 32'd0);
    send_beats("t3c", 300, 1'b0, 1'b0, 1'b0);
    chk("t3c_valid", 32'(bus.tile_valid_o), 32'd1);
    chk("t3c_bank",  32'(bus.tile_bank_o),  32'd5);
    chk_tile("t3c_data", 300);

    // 4: last beat of the second buffer coincides with drain of the first
    send_cmd("t4", 6);
    send_beats("t4", 400, 1'b0, 1'b1, 1'b1);
    bus.tile_ready_i = 1'b0;
    chk("t4_valid",     32'(bus.tile_valid_o), 32'd1);
    chk("t4_bank",      32'(bus.tile_bank_o),  32'd6);
    chk_tile("t4_data", 400);
    chk("t4_busy",      32'(bus.busy_o),       32'd1);
    chk("t4_cmd_ready", 32'(bus.cmd_ready_o),  32'd1);
    drain_one("t4");

    // 5: reset after beat 4 of a fill, then a clean reload
    send_cmd("t5", 4);
    for (int k = 0; k < 5; k++) begin
      bus.hbm_valid_i = 1'b1;
      bus.hbm_data_i  = mk_beat(900, k);
      tick();
    end
    bus.hbm_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_tile_valid", 32'(bus.tile_valid_o), 32'd0);
    chk("t5_rst_hbm_ready",  32'(bus.hbm_ready_o),  32'd0);
    chk("t5_rst_busy",       32'(bus.busy_o),       32'd0);
    chk("t5_rst_cmd_ready",  32'(bus.cmd_ready_o),  32'd1);
    chk("t5_rst_tile_bank",  32'(bus.tile_bank_o),  32'd0);
    chk("t5_rst_data_nonzero", 32'(|bus.tile_data_o), 32'd0);
`ifdef HBM_TILE_LOADER_PERF_EN
    chk("t5_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    send_cmd("t5", 7);
    send_beats("t5", 500, 1'b0, 1'b0, 1'b0);
    chk("t5_valid", 32'(bus.tile_valid_o), 32'd1);
    chk("t5_bank",  32'(bus.tile_bank_o),  32'd7);
    chk_tile("t5_data", 500);
    drain_one("t5");

    // 6: four tiles back to back with the output always ready
    issued   = 0;
    filled   = 0;
    beat_k   = 0;
    drained  = 0;
    last_cyc = -1;
    cyc      = 0;
    bus.tile_ready_i = 1'b1;
    while (drained < 4 && cyc < 100) begin
      bus.cmd_valid_i = (issued < 4);
      bus.cmd_bank_i  = bank_t'(issued);
      bus.hbm_valid_i = (filled < 4);
      bus.hbm_data_i  = mk_beat(1000 * (filled + 1), beat_k);
      cmd_hs  = (issued < 4) && (bus.cmd_ready_o === 1'b1);
      beat_hs = (filled < 4) && (bus.hbm_ready_o === 1'b1);
      if (bus.tile_valid_o === 1'b1) begin
        chk("t6_bank", 32'(bus.tile_bank_o), 32'(drained));
        chk_tile("t6_data", 1000 * (drained + 1));
        if (last_cyc >= 0) chk("t6_interval", 32'(cyc - last_cyc), 32'd9);
        $display("tile t6 #%0d at cycle %0d", drained, cyc);
        last_cyc = cyc;
        drained++;
      end
      tick();
      cyc++;
      if (cmd_hs) issued++;
      if (beat_hs) begin
        beat_k++;
        if (beat_k == BEATS) begin
          beat_k = 0;
          filled++;
        end
      end
    end
    bus.cmd_valid_i  = 1'b0;
    bus.hbm_valid_i  = 1'b0;
    bus.tile_ready_i = 1'b0;
    chk("t6_drained", 32'(drained), 32'd4);
    tick();
    chk("t6_final_busy", 32'(bus.busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
